dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer placed in front of the 16-bit data memory (24 words, combinational read, synchronous write). It shares the single memory port between the CPU MEM stage (port 0) and the debug/program-loader port (port 1). It uses round-robin selection, a fixed three-state access sequence, and out-of-range address checking. It produces the handshake the pipeline uses to stall loads and stores.

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter_rr_arb2.sv | 21 ++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 24;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Word addresses at or beyond DEPTH do not exist in the memory.
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return (addr < AW'(DEPTH));
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic          err0;
    logic          err1;
    logic [DW-1:0] rdata;
    logic          cpu_stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] mem_rdata;

    // Arbiter view.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, err0, err1, rdata, cpu_stall,
               mem_addr, mem_wdata, mem_write, mem_read
    );

    // Requester and memory view.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, err0, err1, rdata, cpu_stall,
               mem_addr, mem_wdata, mem_write, mem_read
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker: on contention the port that was not
// granted last wins; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage (port 0)
// and the debug/loader port (port 1). Each access runs IDLE -> ACCESS -> ACK,
// so one access completes every three cycles.
//
// state  | meaning
// IDLE   | waiting for a request; the winner is latched on the edge
// ACCESS | memory driven from the latched request; read data captured
// ACK    | one-cycle ack (and err) to the latched port; requests ignored
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_t        state;
    logic          last;
    logic          idx_l;
    logic          we_l;
    logic [AW-1:0] addr_l;
    logic [DW-1:0] wdata_l;
    logic          gnt_idx;
    logic          gnt_valid;
    logic          addr_ok;
    logic          in_access;

    rr_arb2 u_rr_arb2 (
        .req       ({bus.req1, bus.req0}),
        .last      (last),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign addr_ok   = addr_in_range(addr_l);
    assign in_access = (state == ACCESS);

    // Memory is only driven during ACCESS, and never for an out-of-range address.
    always_comb begin
        bus.mem_addr  = in_access ? addr_l  : '0;
        bus.mem_wdata = in_access ? wdata_l : '0;
        bus.mem_read  = in_access & ~we_l & addr_ok;
        bus.mem_write = in_access &  we_l & addr_ok;
    end

    // The CPU stalls for as long as its request is outstanding.
    assign bus.cpu_stall = bus.req0 & ~bus.ack0;

    // Access sequencer with registered ack/err/rdata.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= PORT_DBG;
            idx_l     <= PORT_CPU;
            we_l      <= 1'b0;
            addr_l    <= '0;
            wdata_l   <= '0;
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            bus.err0  <= 1'b0;
            bus.err1  <= 1'b0;
            bus.rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        idx_l   <= gnt_idx;
                        last    <= gnt_idx;
                        we_l    <= gnt_idx ? bus.we1    : bus.we0;
                        addr_l  <= gnt_idx ? bus.addr1  : bus.addr0;
                        wdata_l <= gnt_idx ? bus.wdata1 : bus.wdata0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.rdata <= bus.mem_read ? bus.mem_rdata : '0;
                    bus.ack0  <= (idx_l == PORT_CPU);
                    bus.ack1  <= (idx_l == PORT_DBG);
                    bus.err0  <= (idx_l == PORT_CPU) & ~addr_ok;
                    bus.err1  <= (idx_l == PORT_DBG) & ~addr_ok;
                    state     <= ACK;
                end
                ACK: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.err0 <= 1'b0;
                    bus.err1 <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed accesses, a scoreboard of expected
// responses, and a monitor that checks every ack against it.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory: combinational read, synchronous write, cleared by rst.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.mem_write && bus.mem_addr < AW'(DEPTH)) begin
            mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = (bus.mem_addr < AW'(DEPTH)) ? mem[bus.mem_addr[4:0]] : '0;

    typedef struct {
        logic          port;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   wr_pulses = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack is matched against the oldest expected response.
    exp_t m_e;
    always @(negedge clk) begin
        if (bus.mem_write) wr_pulses++;
        if (bus.ack0 || bus.ack1) begin
            chk("ack_onehot", 32'(bus.ack0 & bus.ack1), 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: ack0=%b ack1=%b, required no ack", bus.ack0, bus.ack1);
            end else begin
                m_e = sb.pop_front();
                chk("ack_port", 32'(bus.ack1), 32'(m_e.port));
                chk("ack_err", 32'(bus.ack1 ? bus.err1 : bus.err0), 32'(m_e.err));
                chk("ack_err_other", 32'(bus.ack1 ? bus.err0 : bus.err1), 0);
                chk("ack_rdata", 32'(bus.rdata), 32'(m_e.rdata));
            end
        end
    end

    task automatic drive(input logic port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end
    endtask

    task automatic drop(input logic port);
        if (port) bus.req1 = 1'b0;
        else      bus.req0 = 1'b0;
    endtask

    task automatic push_exp(input logic port, input logic err, input logic [DW-1:0] rd);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    // Waits (bounded) for this port's ack; returns its cycle or -1.
    task automatic wait_ack(input logic port, output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? bus.ack1 : bus.ack0) begin
                c = cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL ack_timeout: port %0d got no ack in 20 cycles, required one", port);
    endtask

    // One complete access from an idle arbiter; checks sample-to-ack latency.
    task automatic access(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic exp_err,
                          input logic [DW-1:0] exp_rd);
        int c0, c1;
        @(posedge clk); #1;
        push_exp(port, exp_err, exp_rd);
        drive(port, we, addr, wd);
        c0 = cyc;
        wait_ack(port, c1);
        drop(port);
        if (c1 >= 0) chk("ack_latency", 32'(c1 - c0), 2);
    endtask

    // Both ports hold reads; expect alternating grants starting at port 0.
    task automatic contend(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int n);
        int got = 0;
        int prev_c = 0;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) push_exp(k % 2 == 1, 1'b0, (k % 2 == 1) ? d1 : d0);
        drive(1'b0, 1'b0, a0, '0);
        drive(1'b1, 1'b0, a1, '0);
        for (int i = 0; i < 12 * n && got < n; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                chk("grant_order", 32'(bus.ack1), 32'(got % 2));
                if (got > 0) chk("ack_spacing", 32'(cyc - prev_c), 3);
                prev_c = cyc;
                got++;
            end
        end
        drop(1'b0);
        drop(1'b1);
        if (got < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL contend_timeout: got %0d acks, required %0d", got, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

        // Reset state.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'({bus.ack1, bus.ack0}), 0);
        chk("rst_err", 32'({bus.err1, bus.err0}), 0);
        chk("rst_rdata", 32'(bus.rdata), 0);
        chk("rst_mem_ctl", 32'({bus.mem_read, bus.mem_write}), 0);
        chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_stall_noreq", 32'(bus.cpu_stall), 0);
        bus.req0 = 1'b1;
        #1;
        chk("rst_stall_req0", 32'(bus.cpu_stall), 1);
        bus.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Write then read back through port 0.
        wr_pulses = 0;
        access(1'b0, 1'b1, 16'd5, 16'hBEEF, 1'b0, 16'h0000);
        chk("write_pulse_count", 32'(wr_pulses), 1);
        access(1'b0, 1'b0, 16'd5, 16'h0000, 1'b0, 16'hBEEF);
        access(1'b0, 1'b1, 16'd1, 16'h1111, 1'b0, 16'h0000);
        access(1'b0, 1'b1, 16'd2, 16'h2222, 1'b0, 16'h0000);
        access(1'b0, 1'b1, 16'd23, 16'hA5A5, 1'b0, 16'h0000);

        // Out-of-range write must not touch memory and must report err1.
        wr_pulses = 0;
        access(1'b1, 1'b1, 16'd24, 16'h1234, 1'b1, 16'h0000);
        chk("oor_no_write", 32'(wr_pulses), 0);
        access(1'b1, 1'b0, 16'd23, 16'h0000, 1'b0, 16'hA5A5);

        // Continuous contention after a port-1 grant.
        contend(16'd1, 16'd2, 16'h1111, 16'h2222, 4);

        // CPU request arrives while port 1 is mid-access.
        fork
            access(1'b1, 1'b0, 16'd5, 16'h0000, 1'b0, 16'hBEEF);
            begin
                @(posedge clk);
                @(posedge clk); #1;
                push_exp(1'b0, 1'b0, 16'hA5A5);
                drive(1'b0, 1'b0, 16'd23, '0);
                c = -1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (bus.ack0) begin
                        chk("stall_in_ack0", 32'(bus.cpu_stall), 0);
                        c = cyc;
                        break;
                    end
                    chk("stall_while_waiting", 32'(bus.cpu_stall), 1);
                end
                drop(1'b0);
                if (c < 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stall_timeout: no ack0, required one");
                end
            end
        join

        // Reset during the ACCESS cycle of a write aborts it.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 16'd3, 16'h00FF);
        @(posedge clk); #1;
        chk("abort_in_access", 32'(bus.mem_write), 1);
        rst = 1'b0;
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack", 32'({bus.ack1, bus.ack0}), 0);
        chk("abort_rdata", 32'(bus.rdata), 0);
        chk("abort_mem_ctl", 32'({bus.mem_read, bus.mem_write}), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ack", 32'({bus.ack1, bus.ack0}), 0);
        end
        contend(16'd3, 16'd3, 16'h0000, 16'h0000, 2);

        // Quiet period: nothing driven, rdata retained.
        access(1'b0, 1'b1, 16'd7, 16'h5A5A, 1'b0, 16'h0000);
        access(1'b0, 1'b0, 16'd7, 16'h0000, 1'b0, 16'h5A5A);
        repeat (10) begin
            @(negedge clk);
            chk("idle_mem_ctl", 32'({bus.mem_read, bus.mem_write}), 0);
            chk("idle_mem_bus", {bus.mem_addr, bus.mem_wdata}, 0);
            chk("idle_ack", 32'({bus.ack1, bus.ack0}), 0);
            chk("idle_rdata_hold", 32'(bus.rdata), 32'h5A5A);
        end

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
